nf10_shell: RTL and testbench

- Template AXI4-Stream shell for a NetFPGA-10G user pcore.
- Accepts packets on a slave stream, buffers them in a small synchronous FIFO, and replays them unmodified on a master stream.
- Provides elastic decoupling between the upstream and downstream datapath stages.
- Serves as the skeleton into which per-project packet processing is later inserted.

---
 rtl/nf10_shell_pkg.sv | 15 +
 rtl/nf10_shell_fifo.sv | 93 +++++++++
 rtl/nf10_shell.sv | 76 +++++++
 tb/tb_nf10_shell.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_shell_pkg.sv
// Shared sizing helpers for the nf10_shell AXI4-Stream pass-through pcore.
// A FIFO entry packs {tlast, tuser, tstrb, tdata} into one word.
package nf10_shell_pkg;

    localparam int MIN_FIFO_DEPTH_BITS = 1;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int entry_width(input int data_width, input int user_width);
        return data_width + strb_width(data_width) + user_width + 1;
    endfunction

endpackage

// File: rtl/nf10_shell_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Ready and valid are registered, so neither side sees a combinational path from the other.
module nf10_shell_fifo
    import nf10_shell_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   occupancy
);

    localparam int                DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr_nxt;
    logic [DEPTH_BITS:0]   count;
    logic [DEPTH_BITS:0]   count_nxt;
    logic [WIDTH-1:0]      head_nxt;
    logic                  push;
    logic                  pop;

    assign push = wr_en && wr_ready;
    assign pop  = rd_en && rd_valid;

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + DEPTH_BITS'(1);
        end
        case ({push, pop})
            2'b10:   count_nxt = count + (DEPTH_BITS + 1)'(1);
            2'b01:   count_nxt = count - (DEPTH_BITS + 1)'(1);
            default: count_nxt = count;
        endcase
        // The incoming word becomes the head when it lands in the slot being exposed next.
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wr_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // NOTE: storage is not reset; count gates what is visible, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            wr_ready <= (count_nxt != DEPTH_CNT);
            rd_valid <= (count_nxt != '0);
            // Head only moves on traffic, which keeps it stable while stalled.
            if (push || pop) begin
                rd_data <= head_nxt;
            end
        end
    end

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign occupancy = count;

endmodule

// File: rtl/nf10_shell.sv
// NetFPGA-10G user pcore shell: buffers the slave AXI4-Stream and replays it unmodified.
// Per-project packet processing is later inserted between the FIFO and the master port.
module nf10_shell
    import nf10_shell_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_FIFO_DEPTH_BITS    = 4
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser
);

    localparam int DATA_W  = C_S_AXIS_DATA_WIDTH;
    localparam int STRB_W  = strb_width(C_S_AXIS_DATA_WIDTH);
    localparam int USER_W  = C_S_AXIS_TUSER_WIDTH;
    localparam int ENTRY_W = entry_width(C_S_AXIS_DATA_WIDTH, C_S_AXIS_TUSER_WIDTH);
    localparam int STRB_LO = DATA_W;
    localparam int USER_LO = DATA_W + STRB_W;
    localparam int LAST_B  = DATA_W + STRB_W + USER_W;

    logic [ENTRY_W-1:0]         wr_entry;
    logic [ENTRY_W-1:0]         rd_entry;
    logic                       fifo_wr_ready;
    logic                       fifo_rd_valid;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [C_FIFO_DEPTH_BITS:0] fifo_occupancy;
    logic                       unused_fifo_status;

    assign wr_entry = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    nf10_shell_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_BITS (C_FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk       (axi_aclk),
        .rst_n     (axi_resetn),
        .wr_en     (s_axis_tvalid),
        .wr_data   (wr_entry),
        .wr_ready  (fifo_wr_ready),
        .rd_en     (m_axis_tready),
        .rd_valid  (fifo_rd_valid),
        .rd_data   (rd_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occupancy)
    );

    // Status is kept for the processing stage that will be inserted here later.
    assign unused_fifo_status = ^{fifo_full, fifo_empty, fifo_occupancy};

    assign s_axis_tready = fifo_wr_ready;
    assign m_axis_tvalid = fifo_rd_valid;
    assign m_axis_tdata  = rd_entry[DATA_W-1:0];
    assign m_axis_tstrb  = rd_entry[STRB_LO +: STRB_W];
    assign m_axis_tuser  = rd_entry[USER_LO +: USER_W];
    assign m_axis_tlast  = rd_entry[LAST_B];

endmodule

// File: tb/tb_nf10_shell.sv
// Self-checking bench for nf10_shell: directed vector table plus hand-written corner sequences,
// with a scoreboard built from what the bench itself pushed.
module tb_nf10_shell;

    localparam int DW = 32;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int DB = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [DW-1:0] exp_data;
        logic          exp_last;
    } vec_t;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic [DW-1:0] s_tdata;
    logic [SW-1:0] s_tstrb;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;

    int    n_checks = 0;
    int    n_errors = 0;
    int    n_pops   = 0;
    beat_t exp_q[$];
    vec_t  pkt[16];

    nf10_shell #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .C_FIFO_DEPTH_BITS    (DB)
    ) u_dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and stall-stability monitor, sampling pre-edge values at each rising edge.
    logic          stall_prev;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_strb;
    logic [UW-1:0] prev_user;
    logic          prev_last;

    always @(posedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", m_tvalid, 1'b1);
                check("stall_data", m_tdata, prev_data);
                check("stall_ctl", {m_tlast, m_tstrb}, {prev_last, prev_strb});
                check("stall_user", m_tuser, prev_user);
            end
            if (m_tvalid && m_tready) begin
                n_pops <= n_pops + 1;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", m_tdata, e.data);
                    check("sb_strb_last", {m_tlast, m_tstrb}, {e.last, e.strb});
                    check("sb_user", m_tuser, e.user);
                end
            end
            if (s_tvalid && s_tready) begin
                exp_q.push_back(beat_t'({s_tlast, s_tuser, s_tstrb, s_tdata}));
            end
            stall_prev <= m_tvalid && !m_tready;
            prev_data  <= m_tdata;
            prev_strb  <= m_tstrb;
            prev_user  <= m_tuser;
            prev_last  <= m_tlast;
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic [SW-1:0] strb,
                             input logic last, input bit toggle);
        bit acc;
        int n;
        s_tdata  = d;
        s_tstrb  = strb;
        s_tlast  = last;
        s_tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            acc = s_tready;
            tick();
            if (toggle) m_tready = ~m_tready;
            n++;
        end
        if (!acc) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_pkt(input int len, input logic [15:0] tag, input bit toggle);
        s_tuser = {tag, 16'h1111, ~tag, 16'h2222, tag, 16'h3333, ~tag, 16'h4444};
        for (int i = 0; i < len; i++) begin
            send_word({tag, 16'(i)}, SW'(i ^ 5) | SW'(1), (i == len - 1), toggle);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit toggle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
            tick();
            if (toggle) m_tready = ~m_tready;
            n++;
        end
        check("drain_done", {exp_q.size() == 0, m_tvalid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n    = 1'b1;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        m_tready = 1'b0;

        pkt[0] = '{32'hFECAFECA, 1'b0, 32'hFECAFECA, 1'b0};
        pkt[1] = '{32'hEFBEEFBE, 1'b0, 32'hEFBEEFBE, 1'b0};
        for (int i = 0; i < 14; i++) begin
            pkt[i + 2] = '{{4{8'(i)}}, (i == 13), {4{8'(i)}}, (i == 13)};
        end

        // Reset held for 50 cycles, then released mid-cycle.
        #1 rst_n = 1'b0;
        repeat (50) tick();
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, '0);
        check("rst_m_side", {m_tlast, m_tstrb, m_tuser}, '0);
        #2 rst_n = 1'b1;
        tick();
        check("rel_s_tready", s_tready, 1'b1);
        check("rel_m_tvalid", m_tvalid, 1'b0);

        // Single 16-word packet with continuous downstream ready.
        m_tready = 1'b1;
        s_tuser  = 128'hCAFEBEEFDEADCAFE;
        s_tstrb  = 4'hF;
        for (int k = 0; k < 16; k++) begin
            s_tdata  = pkt[k].data;
            s_tlast  = pkt[k].last;
            s_tvalid = 1'b1;
            check("pkt_s_tready", s_tready, 1'b1);
            tick();
            check("pkt_m_tvalid", m_tvalid, 1'b1);
            check("pkt_m_tdata", m_tdata, pkt[k].exp_data);
            check("pkt_m_tlast", m_tlast, pkt[k].exp_last);
            check("pkt_m_tuser", m_tuser, 128'hCAFEBEEFDEADCAFE);
            check("pkt_m_tstrb", m_tstrb, 4'hF);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        check("pkt_end_valid", m_tvalid, 1'b0);
        check("pkt_sb_empty", exp_q.size(), 0);

        // Downstream ready toggling every cycle, packets separated by 128 idle cycles.
        send_pkt(5, 16'hA5A5, 1'b1);
        repeat (128) begin tick(); m_tready = ~m_tready; end
        send_pkt(9, 16'h3C3C, 1'b1);
        repeat (128) begin tick(); m_tready = ~m_tready; end
        send_pkt(16, 16'h0F0F, 1'b1);
        wait_drain(300, 1'b1);

        // Fill to 16 with downstream stalled, then a single-cycle pop.
        m_tready = 1'b0;
        tick();
        s_tuser = 128'h5;
        s_tstrb = 4'hF;
        for (int i = 0; i < 16; i++) begin
            s_tdata  = 32'hF000_0000 | 32'(i);
            s_tlast  = (i == 15);
            s_tvalid = 1'b1;
            check("full_ready_before", s_tready, 1'b1);
            tick();
        end
        check("full_ready_drop", s_tready, 1'b0);
        check("full_occupancy", u_dut.u_fifo.occupancy, 5'd16);
        check("full_head", m_tdata, 32'hF000_0000);
        s_tdata = 32'hF000_0010;
        s_tlast = 1'b0;
        tick();
        check("full_no_accept", u_dut.u_fifo.occupancy, 5'd16);
        check("full_ready_held", s_tready, 1'b0);
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        check("full_pop_head", m_tdata, 32'hF000_0001);
        check("full_ready_return", s_tready, 1'b1);
        check("full_pop_occ", u_dut.u_fifo.occupancy, 5'd15);
        tick();
        check("full_refill_ready", s_tready, 1'b0);
        check("full_refill_occ", u_dut.u_fifo.occupancy, 5'd16);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        wait_drain(100, 1'b0);

        // Simultaneous push and pop while holding occupancy at 5.
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tdata  = 32'h0000_00A0 + 32'(i);
            s_tlast  = 1'b0;
            s_tvalid = 1'b1;
            tick();
        end
        check("occ5_fill", u_dut.u_fifo.occupancy, 5'd5);
        check("occ5_head", m_tdata, 32'h0000_00A0);
        m_tready = 1'b1;
        for (int k = 5; k < 8; k++) begin
            s_tdata = 32'h0000_00A0 + 32'(k);
            s_tlast = (k == 7);
            check("occ5_ready", s_tready, 1'b1);
            tick();
            check("occ5_steady", u_dut.u_fifo.occupancy, 5'd5);
            check("occ5_order", m_tdata, 32'h0000_00A0 + 32'(k - 4));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        wait_drain(100, 1'b0);

        // Asynchronous reset with three words of a packet buffered.
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tdata  = 32'hB000_0000 + 32'(i);
            s_tvalid = 1'b1;
            tick();
        end
        s_tvalid = 1'b0;
        check("mid_valid_before", m_tvalid, 1'b1);
        check("mid_occ_before", u_dut.u_fifo.occupancy, 5'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_valid", m_tvalid, 1'b0);
        check("mid_async_ready", s_tready, 1'b0);
        check("mid_async_data", m_tdata, '0);
        exp_q.delete();
        repeat (3) tick();
        #2 rst_n = 1'b1;
        tick();
        check("mid_rel_occ", u_dut.u_fifo.occupancy, 5'd0);
        check("mid_rel_valid", m_tvalid, 1'b0);
        check("mid_rel_ready", s_tready, 1'b1);
        base = n_pops;
        m_tready = 1'b1;
        send_pkt(4, 16'hC0DE, 1'b0);
        wait_drain(50, 1'b0);
        check("mid_clean_pops", n_pops - base, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
